// File: rtl/hazard_pkg.sv
// Shared definitions for the EX-stage forwarding and interlock unit.
// Holds the MULT/DIV sequencer state encoding and the special register numbers.
package hazard_pkg;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int HI_NUM_DEF = 32;
    localparam int LO_NUM_DEF = 33;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/fwd_port_mux.sv
// One EX operand port: MEM/WB hit detection, MEM-over-WB priority select,
// and load-use detection against the MEM-stage load.
module fwd_port_mux
    import hazard_pkg::*;
#(
    parameter int REG_W  = 7,
    parameter int DATA_W = 32
) (
    input  logic [REG_W-1:0]  rd_num_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [REG_W-1:0]  mem_num_i,
    input  logic              mem_write_i,
    input  logic              mem_load_i,
    input  logic [DATA_W-1:0] mem_alu_i,
    input  logic [REG_W-1:0]  wb_num_i,
    input  logic              wb_write_i,
    input  logic              wb_load_i,
    input  logic [DATA_W-1:0] wb_alu_i,
    input  logic [DATA_W-1:0] wb_rdata_i,
    output logic [DATA_W-1:0] data_o,
    output logic              memhit_o,
    output logic              lu_o
);

    logic zero;
    logic wbhit;

    assign zero     = (rd_num_i == REG_W'(REG_ZERO));
    assign memhit_o = !zero && mem_write_i && (rd_num_i == mem_num_i);
    assign wbhit    = !zero && wb_write_i && (rd_num_i == wb_num_i);
    // A MEM load hit cannot forward yet; the value only exists once it reaches WB.
    assign lu_o     = memhit_o && mem_load_i;

    always_comb begin
        data_o = rd_data_i;
        if (memhit_o) begin
            data_o = mem_alu_i;
        end else if (wbhit) begin
            data_o = wb_load_i ? wb_rdata_i : wb_alu_i;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding with load-use and MULT/DIV HI/LO interlocks,
// plus a saturating count of stalled cycles.
//
// state   | meaning
// MD_IDLE | no MULT/DIV in flight; HI/LO reads proceed
// MD_BUSY | MULT/DIV in flight; HI/LO reads and a new MULT/DIV stall
module forward_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_READ   = 2,
    parameter int REG_W      = 7,
    parameter int DATA_W     = 32,
    parameter int MD_LATENCY = 32,
    parameter int HI_NUM     = HI_NUM_DEF,
    parameter int LO_NUM     = LO_NUM_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_READ*REG_W-1:0]    ReadRegisterNumber,
    input  logic [NUM_READ*DATA_W-1:0]   ReadRegisterData,
    input  logic [REG_W-1:0]             MEMRegisterNumber,
    input  logic                         MEMWrite,
    input  logic                         MEMLoad,
    input  logic [DATA_W-1:0]            MEMAluResultData,
    input  logic [REG_W-1:0]             WBRegisterNumber,
    input  logic                         WBWrite,
    input  logic                         WBLoad,
    input  logic [DATA_W-1:0]            WBAluResultData,
    input  logic [DATA_W-1:0]            WBReadData,
    input  logic                         MdStart,
    input  logic                         Flush,
    output logic [NUM_READ*DATA_W-1:0]   EXRegisterData,
    output logic                         Stall,
    output logic                         MdBusy,
    output logic [31:0]                  StallCount
);

    localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_dec;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic [NUM_READ-1:0] memhit, lu, hilo_rd;
    logic              load_stall, md_stall;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        fwd_port_mux #(
            .REG_W  (REG_W),
            .DATA_W (DATA_W)
        ) u_mux (
            .rd_num_i    (ReadRegisterNumber[i*REG_W +: REG_W]),
            .rd_data_i   (ReadRegisterData[i*DATA_W +: DATA_W]),
            .mem_num_i   (MEMRegisterNumber),
            .mem_write_i (MEMWrite),
            .mem_load_i  (MEMLoad),
            .mem_alu_i   (MEMAluResultData),
            .wb_num_i    (WBRegisterNumber),
            .wb_write_i  (WBWrite),
            .wb_load_i   (WBLoad),
            .wb_alu_i    (WBAluResultData),
            .wb_rdata_i  (WBReadData),
            .data_o      (EXRegisterData[i*DATA_W +: DATA_W]),
            .memhit_o    (memhit[i]),
            .lu_o        (lu[i])
        );

        assign hilo_rd[i] = (ReadRegisterNumber[i*REG_W +: REG_W] == REG_W'(HI_NUM)) ||
                            (ReadRegisterNumber[i*REG_W +: REG_W] == REG_W'(LO_NUM));
    end

    assign load_stall = |(lu & memhit);
    assign MdBusy     = (state_q == MD_BUSY);
    assign md_stall   = MdBusy && ((|hilo_rd) || MdStart);
    assign Stall      = load_stall || md_stall;
    assign StallCount = stall_cnt_q;

    assign cnt_dec = cnt_q - 1'b1;

    // The counter is loaded with LATENCY-1 and the FSM leaves BUSY as the
    // decremented value reaches zero, so MdBusy spans t+1..t+LATENCY-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (MdStart && !Stall && !Flush) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (Flush) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = MD_IDLE;
                    end
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench for forward_hazard_unit: the driver queues hand-computed
// expectations per vector, a negedge monitor pops and compares them.
module tb_forward_hazard_unit;

    localparam int NR = 2;
    localparam int RW = 7;
    localparam int DW = 32;
    localparam int MDL = 4;

    localparam logic [4:0] M_P0 = 5'b00001;
    localparam logic [4:0] M_P1 = 5'b00010;
    localparam logic [4:0] M_ST = 5'b00100;
    localparam logic [4:0] M_BZ = 5'b01000;
    localparam logic [4:0] M_CN = 5'b10000;

    typedef struct {
        string       name;
        logic [4:0]  mask;
        logic [31:0] p0;
        logic [31:0] p1;
        logic        stall;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [NR*RW-1:0] rnum;
    logic [NR*DW-1:0] rdata;
    logic [RW-1:0]    mem_num;
    logic             mem_write, mem_load;
    logic [DW-1:0]    mem_alu;
    logic [RW-1:0]    wb_num;
    logic             wb_write, wb_load;
    logic [DW-1:0]    wb_alu, wb_rdata;
    logic             md_start, flush;
    logic [NR*DW-1:0] exreg;
    logic             stall, md_busy;
    logic [31:0]      stall_count;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    forward_hazard_unit #(
        .NUM_READ   (NR),
        .REG_W      (RW),
        .DATA_W     (DW),
        .MD_LATENCY (MDL)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ReadRegisterNumber (rnum),
        .ReadRegisterData   (rdata),
        .MEMRegisterNumber  (mem_num),
        .MEMWrite           (mem_write),
        .MEMLoad            (mem_load),
        .MEMAluResultData   (mem_alu),
        .WBRegisterNumber   (wb_num),
        .WBWrite            (wb_write),
        .WBLoad             (wb_load),
        .WBAluResultData    (wb_alu),
        .WBReadData         (wb_rdata),
        .MdStart            (md_start),
        .Flush              (flush),
        .EXRegisterData     (exreg),
        .Stall              (stall),
        .MdBusy             (md_busy),
        .StallCount         (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, exp);
    endtask

    // Monitor: outputs are combinational, so every queued vector is due at the next negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.mask[0]) cmp(e.name, "p0",    exreg[31:0],  e.p0);
                if (e.mask[1]) cmp(e.name, "p1",    exreg[63:32], e.p1);
                if (e.mask[2]) cmp(e.name, "stall", {31'd0, stall},   {31'd0, e.stall});
                if (e.mask[3]) cmp(e.name, "busy",  {31'd0, md_busy}, {31'd0, e.busy});
                if (e.mask[4]) cmp(e.name, "cnt",   stall_count, e.cnt);
            end
        end
    end

    task automatic expect_v(input string nm, input logic [4:0] m, input logic [31:0] p0,
                            input logic [31:0] p1, input logic st, input logic bz, input logic [31:0] cn);
        exp_t e;
        e.name = nm; e.mask = m; e.p0 = p0; e.p1 = p1; e.stall = st; e.busy = bz; e.cnt = cn;
        sb.push_back(e);
    endtask

    task automatic clr();
        rnum = '0; rdata = '0;
        mem_num = '0; mem_write = 0; mem_load = 0; mem_alu = '0;
        wb_num = '0; wb_write = 0; wb_load = 0; wb_alu = '0; wb_rdata = '0;
        md_start = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic setp(input int port, input logic [RW-1:0] num, input logic [DW-1:0] data);
        rnum[port*RW +: RW]  = num;
        rdata[port*DW +: DW] = data;
    endtask

    localparam logic [4:0] M_SBC = M_ST | M_BZ | M_CN;

    initial begin
        rst_n = 0;
        clr();
        setp(0, 7'd3, 32'h0000_00AB);
        expect_v("reset", M_P0 | M_SBC, 32'hAB, 0, 0, 0, 0);
        @(negedge clk);
        #1;

        step(); rst_n = 1;
        setp(0, 7'd5, 32'h99);
        mem_num = 5; mem_write = 1; mem_alu = 32'h11;
        wb_num = 5; wb_write = 1; wb_alu = 32'h22;
        expect_v("mem_over_wb", M_P0 | M_ST, 32'h11, 0, 0, 0, 0);

        step();
        setp(0, 7'd5, 32'h99);
        mem_num = 5; mem_write = 0; mem_alu = 32'h11;
        wb_num = 5; wb_write = 1; wb_alu = 32'h22;
        expect_v("wb_alu", M_P0 | M_ST, 32'h22, 0, 0, 0, 0);

        step();
        setp(0, 7'd5, 32'h99);
        wb_num = 5; wb_write = 1; wb_load = 1; wb_alu = 32'h22; wb_rdata = 32'h33;
        expect_v("wb_load", M_P0, 32'h33, 0, 0, 0, 0);

        step();
        setp(1, 7'd0, 32'h0);
        mem_num = 0; mem_write = 1; mem_load = 1; mem_alu = 32'hFF;
        wb_num = 0; wb_write = 1; wb_alu = 32'hEE;
        expect_v("zero_reg", M_P1 | M_ST, 0, 32'h0, 0, 0, 0);

        step();
        setp(0, 7'd7, 32'h1234);
        mem_num = 5; mem_write = 1; mem_alu = 32'h11;
        wb_num = 6; wb_write = 1; wb_alu = 32'h22;
        expect_v("no_hit", M_P0, 32'h1234, 0, 0, 0, 0);

        step();
        setp(0, 7'd6, 32'hABC);
        wb_num = 6; wb_write = 0; wb_alu = 32'h22;
        expect_v("wb_nowrite", M_P0, 32'hABC, 0, 0, 0, 0);

        step();
        setp(0, 7'd8, 32'h1);
        mem_num = 8; mem_write = 1; mem_load = 1; mem_alu = 32'h55;
        expect_v("lu_stall", M_P0 | M_SBC, 32'h55, 0, 1, 0, 0);

        step();
        setp(0, 7'd8, 32'h1);
        wb_num = 8; wb_write = 1; wb_load = 1; wb_alu = 32'h1; wb_rdata = 32'hDEAD;
        expect_v("lu_resolved", M_P0 | M_SBC, 32'hDEAD, 0, 0, 0, 1);

        step();
        setp(1, 7'd9, 32'h2);
        mem_num = 9; mem_write = 1; mem_load = 1; mem_alu = 32'h66;
        expect_v("lu_port1", M_P1 | M_SBC, 0, 32'h66, 1, 0, 1);

        step();
        setp(1, 7'd9, 32'h2);
        mem_num = 9; mem_write = 0; mem_load = 1; mem_alu = 32'h66;
        expect_v("load_nowrite", M_P1 | M_SBC, 0, 32'h2, 0, 0, 2);

        // MULT/DIV with latency 4 issued at t
        step(); md_start = 1;
        expect_v("md_t0", M_SBC, 0, 0, 0, 0, 2);
        step(); setp(0, 7'd32, 32'h4242);
        expect_v("md_t1_hi", M_P0 | M_SBC, 32'h4242, 0, 1, 1, 2);
        step(); setp(0, 7'd33, 32'h0);
        expect_v("md_t2_lo", M_SBC, 0, 0, 1, 1, 3);
        step(); setp(1, 7'd32, 32'h0);
        expect_v("md_t3_p1hi", M_SBC, 0, 0, 1, 1, 4);
        step(); setp(0, 7'd32, 32'h4242);
        expect_v("md_t4_free", M_P0 | M_SBC, 32'h4242, 0, 0, 0, 5);

        // second MULT/DIV waits while the first is in flight
        step(); md_start = 1;
        expect_v("md2_t0", M_SBC, 0, 0, 0, 0, 5);
        step(); md_start = 1;
        expect_v("md2_t1", M_SBC, 0, 0, 1, 1, 5);
        step(); md_start = 1;
        expect_v("md2_t2", M_SBC, 0, 0, 1, 1, 6);
        step(); md_start = 1;
        expect_v("md2_t3", M_SBC, 0, 0, 1, 1, 7);
        step(); md_start = 1;
        expect_v("md2_t4_accept", M_SBC, 0, 0, 0, 0, 8);

        // flush at t+2 of the accepted MULT/DIV
        step();
        expect_v("fl_t1", M_SBC, 0, 0, 0, 1, 8);
        step(); flush = 1;
        expect_v("fl_t2", M_SBC, 0, 0, 0, 1, 8);
        step(); setp(0, 7'd32, 32'h0);
        expect_v("fl_t3_hi", M_SBC, 0, 0, 0, 0, 8);

        step(); md_start = 1; flush = 1;
        expect_v("flush_prio", M_SBC, 0, 0, 0, 0, 8);
        step();
        expect_v("flush_prio_n", M_SBC, 0, 0, 0, 0, 8);

        step(); md_start = 1;
        setp(0, 7'd8, 32'h0);
        mem_num = 8; mem_write = 1; mem_load = 1; mem_alu = 32'h77;
        expect_v("start_in_stall", M_P0 | M_SBC, 32'h77, 0, 1, 0, 8);
        step();
        expect_v("start_dropped", M_SBC, 0, 0, 0, 0, 9);

        // reset in the middle of a MULT/DIV
        step(); md_start = 1;
        expect_v("rst_t0", M_SBC, 0, 0, 0, 0, 9);
        step();
        expect_v("rst_t1", M_SBC, 0, 0, 0, 1, 9);
        step(); rst_n = 0;
        expect_v("rst_t2", M_SBC, 0, 0, 0, 0, 0);
        step(); rst_n = 0;
        setp(0, 7'd8, 32'h0);
        mem_num = 8; mem_write = 1; mem_load = 1; mem_alu = 32'h88;
        expect_v("rst_lu", M_SBC, 0, 0, 1, 0, 0);
        step(); rst_n = 1; md_start = 1;
        expect_v("rst_rel_start", M_SBC, 0, 0, 0, 0, 0);
        step(); setp(0, 7'd32, 32'h0);
        expect_v("rst_rel_busy", M_SBC, 0, 0, 1, 1, 0);
        step();
        expect_v("rst_rel_t2", M_SBC, 0, 0, 0, 1, 1);

        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Parametrised EX-stage operand forwarding and interlock unit for the five-stage MIPS pipeline. It replaces the single-operand, combinational forwarding mux. It serves NUM_READ operand ports. Forwarding is qualified by write-enable, with MEM-over-WB priority and load data selected in WB. It also generates the load-use stall and the multi-cycle MULT/DIV interlock on HI/LO, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- NUM_READ, 2: number of EX-stage operand ports.
- REG_W, 7: register-number width; 0 is $zero, and numbers 32/33 are HI/LO.
- DATA_W, 32: datapath width.
- MD_LATENCY, 32: MULT/DIV cycles from start to HI/LO valid; minimum 2.
- HI_NUM, 32 and LO_NUM, 33: register numbers of HI/LO.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ReadRegisterNumber  in  NUM_READ*REG_W  EX operand register numbers; port i at bits [i*REG_W +: REG_W].
- ReadRegisterData  in  NUM_READ*DATA_W  register-file values for the same ports.
- MEMRegisterNumber  in  REG_W  MEM-stage destination.
- MEMWrite  in  1  MEM instruction writes its destination.
- MEMLoad  in  1  MEM instruction is a load.
- MEMAluResultData  in  DATA_W  MEM-stage ALU result.
- WBRegisterNumber  in  REG_W  WB-stage destination.
- WBWrite  in  1  WB instruction writes its destination.
- WBLoad  in  1  WB instruction is a load.
- WBAluResultData  in  DATA_W  WB-stage ALU result.
- WBReadData  in  DATA_W  WB-stage memory data.
- MdStart  in  1  EX instruction is MULT/DIV and is issuing this cycle.
- Flush  in  1  pipeline flush (exception/eret).
- EXRegisterData  out  NUM_READ*DATA_W  final operand values.
- Stall  out  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- MdBusy  out  1  MULT/DIV in flight.
- StallCount  out  32  saturating count of cycles with Stall=1.

## Operation
- Per port i, with zero_i = (number == 0):
  - memhit_i = !zero_i & MEMWrite & (number == MEMRegisterNumber).
  - wbhit_i = !zero_i & WBWrite & (number == WBRegisterNumber).
- Port i output:
  - memhit_i: MEMAluResultData.
  - else wbhit_i: WBLoad ? WBReadData : WBAluResultData.
  - else: ReadRegisterData.
- Load-use: lu_i = memhit_i & MEMLoad; LoadStall = OR over i of lu_i. The MEM load reaches WB next cycle, where forwarding resolves, so the stall lasts exactly one cycle per hazard.
- MD FSM states:
  - IDLE: MdStart & !Stall & !Flush -> BUSY, counter = MD_LATENCY-1.
  - BUSY: decrement the counter each cycle. At counter == 0 -> IDLE.
  - BUSY: Flush -> IDLE, counter = 0. The divider result is discarded by the datapath.
- MdStall is asserted while the FSM is BUSY and either:
  - any port reads HI_NUM or LO_NUM, or
  - MdStart is high (a second MULT/DIV waits).
- Stall = LoadStall | MdStall; combinational, same cycle.
- MdStart is ignored while Stall=1; the instruction re-presents it after the stall.
- Flush has priority over MdStart in IDLE.
- StallCount increments on every cycle with Stall=1 and saturates at 0xFFFFFFFF.

## Timing
- Forwarding and Stall: combinational, zero latency.
- MD: MdStart accepted at cycle t; MdBusy=1 for cycles t+1 through t+MD_LATENCY-1. A HI/LO read is forwarded or read normally at t+MD_LATENCY.
- Reset (any time, including mid-BUSY): FSM=IDLE, counter=0, MdBusy=0, StallCount=0. While reset is held, Stall is driven only by LoadStall and MdBusy=0.
- Simultaneous LoadStall and MdStall: a single Stall. The counter still decrements during stall cycles.

## Structure
- Shared package hazard_pkg holds:
  - the md_state_t enum (IDLE, BUSY);
  - the HI_NUM/LO_NUM defaults;
  - the REG_ZERO constant.
- One sub-module, fwd_port_mux, is instantiated NUM_READ times via generate. It implements the per-port hit/priority/select logic and outputs memhit and lu.
- The FSM, counter and StallCount live in the top level.

## Test plan
- Port0=5, MEM dest 5 with MEMWrite=1 and ALU=0x11, WB dest 5 with ALU=0x22 -> port0=0x11; with MEMWrite=0 -> 0x22.
- Port1=0 with MEM dest 0 writing 0xFF, RF data 0 -> output 0, Stall=0.
- MEM load to $8 and port0=8 -> Stall=1 for one cycle. Next cycle the load is in WB with WBReadData=0xDEAD -> port0=0xDEAD, Stall=0, StallCount=1.
- MD_LATENCY=4, MdStart at t, port reads 32 at t+1..t+4:
  - Stall=1 at t+1..t+3 and 0 at t+4;
  - MdBusy=1 at t+1..t+3.
- Flush at t+2 during BUSY -> MdBusy=0 at t+3, no stall on HI.
- rst_n low at t+2 of a MULT -> MdBusy=0 and StallCount=0 immediately; after release, the FSM is in IDLE and accepts a new MdStart.
